// File: rtl/cam_capture.sv
// Receive side of the camera parallel pixel interface.
// pclk/hsync/vsync are oversampled in the system clock domain. One byte is
// captured per pclk rising edge while the line is valid. Byte pairs are packed
// into 16-bit frame buffer words addressed by line and word position.
module cam_capture #(
  parameter int LINE_BYTES = 320,
  parameter int MAX_LINES  = 240,
  parameter int LINE_W     = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic                  pclk,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [7:0]            cam_data,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [15:0]           wr_data,
  output logic [2*LINE_W-2:0]   wr_addr,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  line_error,
  output logic                  overflow,
  output logic                  busy
);

  localparam int AW = 2*LINE_W-1;
  localparam logic [LINE_W-1:0] LB   = LINE_W'(LINE_BYTES);
  localparam logic [LINE_W-1:0] ML   = LINE_W'(MAX_LINES);
  localparam logic [AW-1:0]     HALF = AW'(LINE_BYTES/2);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t state, state_next;

  logic pclk_s1, pclk_s2, pclk_h;
  logic hsync_s1, hsync_s2, hsync_h;
  logic vsync_s1, vsync_s2, vsync_h;
  logic [7:0] data_d1, data_d2;
  logic [2:0] prime;

  logic pclk_rise, vsync_rise, vsync_fall, hsync_fall;
  logic start_evt, done_evt, capture, line_end;

  logic [LINE_W-1:0] byte_cnt, line_cnt;
  logic [7:0]        hi_byte;
  logic              word_pend;
  logic [15:0]       word_buf;
  logic [AW-1:0]     word_addr;
  logic [AW-1:0]     line_base;

  // Synchronizers, history flops and a data delay that keeps cam_data aligned
  // with the synchronized pclk. prime marks when the history flops hold real
  // input samples, so a vsync that is already high at reset release is never
  // mistaken for a low level (which would arm capture mid-frame).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_h  <= 1'b0;
      hsync_s1 <= 1'b0; hsync_s2 <= 1'b0; hsync_h <= 1'b0;
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_h <= 1'b0;
      data_d1  <= 8'h00; data_d2 <= 8'h00;
      prime    <= 3'b000;
    end else begin
      pclk_s1  <= pclk;     pclk_s2  <= pclk_s1;  pclk_h  <= pclk_s2;
      hsync_s1 <= hsync;    hsync_s2 <= hsync_s1; hsync_h <= hsync_s2;
      vsync_s1 <= vsync;    vsync_s2 <= vsync_s1; vsync_h <= vsync_s2;
      data_d1  <= cam_data; data_d2  <= data_d1;
      prime    <= {prime[1:0], 1'b1};
    end
  end

  assign pclk_rise  = pclk_s2 & ~pclk_h;
  assign vsync_rise = vsync_s2 & ~vsync_h;
  assign vsync_fall = ~vsync_s2 & vsync_h;
  assign hsync_fall = ~hsync_s2 & hsync_h;

  // Capture state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; capture only ever begins from a vsync low level.
  always_comb begin
    state_next = state;
    start_evt  = 1'b0;
    done_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (capture_en && prime[2] && !vsync_s2) state_next = ARMED;
      end
      ARMED: begin
        if (!capture_en) begin
          state_next = IDLE;
        end else if (vsync_rise) begin
          start_evt  = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vsync_fall) begin
          done_evt   = 1'b1;
          state_next = capture_en ? ARMED : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture   = (state == ACTIVE) && pclk_rise && hsync_s2 && (line_cnt < ML);
  assign line_end  = (state == ACTIVE) && hsync_fall;
  assign line_base = AW'(line_cnt) * HALF;
  assign busy      = (state == ARMED) || (state == ACTIVE);

  // Byte packing, line accounting and the registered write port. A word that
  // meets wr_ready low is dropped (the camera cannot be paused) and recorded
  // in the sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt    <= '0;
      line_cnt    <= '0;
      hi_byte     <= 8'h00;
      word_pend   <= 1'b0;
      word_buf    <= 16'h0000;
      word_addr   <= '0;
      wr_en       <= 1'b0;
      wr_data     <= 16'h0000;
      wr_addr     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_error  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      line_error  <= 1'b0;
      word_pend   <= 1'b0;
      frame_start <= start_evt;
      frame_done  <= done_evt;

      if (start_evt) begin
        byte_cnt <= '0;
        line_cnt <= '0;
        overflow <= 1'b0;
      end

      if (capture) begin
        if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt < LB) begin
          if (!byte_cnt[0]) begin
            hi_byte <= data_d2;
          end else begin
            word_pend <= 1'b1;
            word_buf  <= {hi_byte, data_d2};
            word_addr <= line_base + AW'(byte_cnt >> 1);
          end
        end
      end

      if (line_end) begin
        byte_cnt <= '0;
        if (line_cnt < ML) begin
          line_error <= (byte_cnt != LB);
          line_cnt   <= line_cnt + 1'b1;
        end
      end

      if (word_pend) begin
        if (wr_ready) begin
          wr_en   <= 1'b1;
          wr_data <= word_buf;
          wr_addr <= word_addr;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
